// File: rtl/ex_mem_pkg.sv
// EX/MEM pipeline register shared types.
// Widths, NOP constants and the registered MEM bundle.
package ex_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int HILO_W     = 2 * DATA_W;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic                  STOP      = 1'b1;
    localparam logic                  WR_DIS    = 1'b0;
    localparam logic [DATA_W-1:0]     ZERO_WORD = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG   = '0;
    localparam logic [ALUOP_W-1:0]    NOP_OP    = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic                  whilo;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     mem_addr;
        logic [DATA_W-1:0]     reg2;
    } mem_bus_t;

    localparam mem_bus_t MEM_NOP = '{
        wd:       NOP_REG,
        wreg:     WR_DIS,
        wdata:    ZERO_WORD,
        whilo:    WR_DIS,
        hi:       ZERO_WORD,
        lo:       ZERO_WORD,
        aluop:    NOP_OP,
        mem_addr: ZERO_WORD,
        reg2:     ZERO_WORD
    };

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM bundle: EX results + stall in, MEM copies + MADD state out.
// master = EX/stall-controller side, slave = the ex_mem register.
interface ex_mem_if
    import ex_mem_pkg::*;
();

    logic [5:0]            stall;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic                  ex_whilo;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [HILO_W-1:0]     hilo_i;
    logic [1:0]            cnt_i;

    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_whilo;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [HILO_W-1:0]     hilo_o;
    logic [1:0]            cnt_o;

    modport master (
        output stall, ex_wd, ex_wreg, ex_wdata, ex_whilo,
        output ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
        output hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_whilo,
        input  mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2,
        input  hilo_o, cnt_o
    );

    modport slave (
        input  stall, ex_wd, ex_wreg, ex_wdata, ex_whilo,
        input  ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
        input  hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_whilo,
        output mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2,
        output hilo_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: advance, bubble or hold per stall[4:3].
// Ports: clk, rst_n (async, active low), bus (ex_mem_if.slave).
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ex_mem_if.slave  bus
);

    mem_bus_t          ex_b;
    mem_bus_t          mem_q, mem_d;
    logic [HILO_W-1:0] hilo_q, hilo_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ex_stall, mem_stall;
    logic              unused_stall;

    assign ex_stall  = bus.stall[STALL_EX];
    assign mem_stall = bus.stall[STALL_MEM];

    // Only the EX and MEM bits matter to this register.
    assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

    assign ex_b = '{
        wd:       bus.ex_wd,
        wreg:     bus.ex_wreg,
        wdata:    bus.ex_wdata,
        whilo:    bus.ex_whilo,
        hi:       bus.ex_hi,
        lo:       bus.ex_lo,
        aluop:    bus.ex_aluop,
        mem_addr: bus.ex_mem_addr,
        reg2:     bus.ex_reg2
    };

    // EX running wins even if MEM is (illegally) stalled.
    // EX stalled alone: bubble MEM, park the MADD partial
    // product so EX sees it again next cycle.
    always_comb begin
        mem_d  = mem_q;
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
        if (ex_stall != STOP) begin
            mem_d  = ex_b;
            hilo_d = '0;
            cnt_d  = '0;
        end else if (mem_stall != STOP) begin
            mem_d  = MEM_NOP;
            hilo_d = bus.hilo_i;
            cnt_d  = bus.cnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= MEM_NOP;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.mem_wd       = mem_q.wd;
    assign bus.mem_wreg     = mem_q.wreg;
    assign bus.mem_wdata    = mem_q.wdata;
    assign bus.mem_whilo    = mem_q.whilo;
    assign bus.mem_hi       = mem_q.hi;
    assign bus.mem_lo       = mem_q.lo;
    assign bus.mem_aluop    = mem_q.aluop;
    assign bus.mem_mem_addr = mem_q.mem_addr;
    assign bus.mem_reg2     = mem_q.reg2;
    assign bus.hilo_o       = hilo_q;
    assign bus.cnt_o        = cnt_q;

endmodule
